// File: rtl/melody_detector.sv
// Watches the tone generator's note stream for the opening phrase of "Happy Birthday"
// (G G A G C B), tolerating small pitch error and abandoning stale partial matches.
module melody_detector #(
    parameter logic [9:0]  NOTE_G  = 10'd392,
    parameter logic [9:0]  NOTE_A  = 10'd440,
    parameter logic [9:0]  NOTE_B  = 10'd494,
    parameter logic [9:0]  NOTE_C  = 10'd523,
    parameter int unsigned TOL     = 8,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_count_valid,
    input  logic [9:0] i_count,
    output logic [2:0] o_progress,
    output logic       o_detected,
    output logic       o_timeout
);

    localparam logic [10:0] TOL_W        = 11'(TOL);
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

    // State value equals the number of phrase notes matched so far.
    typedef enum logic [2:0] {
        S_P0 = 3'd0,
        S_P1 = 3'd1,
        S_P2 = 3'd2,
        S_P3 = 3'd3,
        S_P4 = 3'd4,
        S_P5 = 3'd5
    } progress_e;

    progress_e   state, state_nxt;
    logic [15:0] idle_cnt, idle_cnt_nxt;
    logic        detected_nxt, timeout_nxt;
    logic [9:0]  expected_note;
    logic        prev_is_g;
    logic        hit_expected, hit_g;

    // Operands are widened by one bit so the subtraction can never wrap.
    function automatic logic note_match(input logic [9:0] x, input logic [9:0] n);
        logic [10:0] xe;
        logic [10:0] ne;
        logic [10:0] diff;
        xe   = {1'b0, x};
        ne   = {1'b0, n};
        diff = (xe >= ne) ? (xe - ne) : (ne - xe);
        return diff <= TOL_W;
    endfunction

    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    always_comb begin
        expected_note = NOTE_G;
        prev_is_g     = 1'b0;
        case (state)
            S_P0:    expected_note = NOTE_G;
            S_P1:    begin expected_note = NOTE_G; prev_is_g = 1'b1; end
            S_P2:    begin expected_note = NOTE_A; prev_is_g = 1'b1; end
            S_P3:    expected_note = NOTE_G;
            S_P4:    begin expected_note = NOTE_C; prev_is_g = 1'b1; end
            S_P5:    expected_note = NOTE_B;
            default: expected_note = NOTE_G;
        endcase
    end

    assign hit_expected = note_match(i_count, expected_note);
    assign hit_g        = note_match(i_count, NOTE_G);

    always_comb begin
        state_nxt    = state;
        idle_cnt_nxt = idle_cnt;
        detected_nxt = 1'b0;
        timeout_nxt  = 1'b0;
        if (i_count_valid) begin
            // A valid note always wins over a timeout in the same cycle.
            idle_cnt_nxt = '0;
            if (hit_expected) begin
                if (state == S_P5) begin
                    state_nxt    = S_P0;
                    detected_nxt = 1'b1;
                end else begin
                    state_nxt = progress_e'(state + 3'd1);
                end
            end else if (hit_g) begin
                // A stray G may itself be the second G of a fresh phrase.
                state_nxt = prev_is_g ? S_P2 : S_P1;
            end else begin
                state_nxt = S_P0;
            end
        end else if (state == S_P0) begin
            idle_cnt_nxt = '0;
        end else if (idle_cnt >= TIMEOUT_LAST) begin
            state_nxt    = S_P0;
            timeout_nxt  = 1'b1;
            idle_cnt_nxt = '0;
        end else if (idle_cnt != 16'hFFFF) begin
            idle_cnt_nxt = idle_cnt + 16'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= S_P0;
            idle_cnt   <= '0;
            o_detected <= 1'b0;
            o_timeout  <= 1'b0;
        end else begin
            state      <= state_nxt;
            idle_cnt   <= idle_cnt_nxt;
            o_detected <= detected_nxt;
            o_timeout  <= timeout_nxt;
        end
    end

    assign o_progress = state;

endmodule

// File: tb/tb_melody_detector.sv
// Table-driven bench for melody_detector: note vectors with expected outputs go through
// a scoreboard queue; the timeout corner cases are hand-written sequences.
module tb_melody_detector;

    localparam logic [9:0] G = 10'd392;
    localparam logic [9:0] A = 10'd440;
    localparam logic [9:0] B = 10'd494;
    localparam logic [9:0] C = 10'd523;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b0;
    logic       i_count_valid = 1'b0;
    logic [9:0] i_count = '0;
    logic [2:0] o_progress;
    logic       o_detected;
    logic       o_timeout;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        string      name;
        logic       rst;
        logic       valid;
        logic [9:0] count;
        int         gap;
        logic [2:0] prog;
        logic       det;
        logic       to;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    melody_detector #(
        .NOTE_G(G), .NOTE_A(A), .NOTE_B(B), .NOTE_C(C), .TOL(8), .TIMEOUT(64)
    ) dut (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .i_count_valid(i_count_valid),
        .i_count(i_count),
        .o_progress(o_progress),
        .o_detected(o_detected),
        .o_timeout(o_timeout)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got prog=%0d det=%0b to=%0b, expected prog=%0d det=%0b to=%0b",
                     name, act[4:2], act[1], act[0], exp[4:2], exp[1], exp[0]);
        end
    endtask

    task automatic add(input string name, input logic rst, input logic valid,
                       input logic [9:0] count, input int gap,
                       input logic [2:0] prog, input logic det, input logic to);
        vec_t v;
        v.name = name; v.rst = rst; v.valid = valid; v.count = count;
        v.gap = gap; v.prog = prog; v.det = det; v.to = to;
        vecs.push_back(v);
    endtask

    // Drive one cycle of stimulus, then compare the registered outputs after the edge.
    task automatic step(input vec_t v);
        vec_t e;
        @(negedge i_clk);
        i_rst = v.rst;
        i_count_valid = v.valid;
        i_count = v.count;
        sb.push_back(v);
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        i_count_valid = 1'b0;
        e = sb.pop_front();
        check(e.name, {o_progress, o_detected, o_timeout}, {e.prog, e.det, e.to});
        repeat (v.gap) @(posedge i_clk);
    endtask

    task automatic step_inline(input string name, input logic rst, input logic valid,
                               input logic [9:0] count, input logic [2:0] prog,
                               input logic det, input logic to);
        vec_t v;
        v.name = name; v.rst = rst; v.valid = valid; v.count = count;
        v.gap = 0; v.prog = prog; v.det = det; v.to = to;
        step(v);
    endtask

    task automatic run_timeout(input logic late_note);
        step_inline("t_reset", 1'b1, 1'b0, 10'd0, 3'd0, 1'b0, 1'b0);
        step_inline("t_g1", 1'b0, 1'b1, G, 3'd1, 1'b0, 1'b0);
        step_inline("t_g2", 1'b0, 1'b1, G, 3'd2, 1'b0, 1'b0);
        step_inline("t_a", 1'b0, 1'b1, A, 3'd3, 1'b0, 1'b0);
        for (int j = 1; j < 64; j++)
            step_inline("t_idle", 1'b0, 1'b0, A, 3'd3, 1'b0, 1'b0);
        if (late_note) begin
            step_inline("t_note_on_timeout", 1'b0, 1'b1, G, 3'd4, 1'b0, 1'b0);
            step_inline("t_after_note", 1'b0, 1'b0, 10'd0, 3'd4, 1'b0, 1'b0);
        end else begin
            step_inline("t_timeout_pulse", 1'b0, 1'b0, 10'd0, 3'd0, 1'b0, 1'b1);
            step_inline("t_timeout_once", 1'b0, 1'b0, 10'd0, 3'd0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        // Scenario 1: exact notes, 10 cycles apart.
        add("s1_reset",   1, 0, 10'd0, 0, 3'd0, 0, 0);
        add("s1_g1",      0, 1, G,     9, 3'd1, 0, 0);
        add("s1_g2",      0, 1, G,     9, 3'd2, 0, 0);
        add("s1_a",       0, 1, A,     9, 3'd3, 0, 0);
        add("s1_g3",      0, 1, G,     9, 3'd4, 0, 0);
        add("s1_c",       0, 1, C,     9, 3'd5, 0, 0);
        add("s1_b_det",   0, 1, B,     0, 3'd0, 1, 0);
        add("s1_det_off", 0, 0, 10'd0, 0, 3'd0, 0, 0);
        // Scenario 2: detuned notes inside and just outside the tolerance.
        add("s2_395",     0, 1, 10'd395, 0, 3'd1, 0, 0);
        add("s2_388",     0, 1, 10'd388, 0, 3'd2, 0, 0);
        add("s2_447",     0, 1, 10'd447, 0, 3'd3, 0, 0);
        add("s2_392",     0, 1, 10'd392, 0, 3'd4, 0, 0);
        add("s2_530",     0, 1, 10'd530, 0, 3'd5, 0, 0);
        add("s2_500_det", 0, 1, 10'd500, 0, 3'd0, 1, 0);
        add("s2b_395",    0, 1, 10'd395, 0, 3'd1, 0, 0);
        add("s2b_388",    0, 1, 10'd388, 0, 3'd2, 0, 0);
        add("s2b_449",    0, 1, 10'd449, 0, 3'd0, 0, 0);
        add("s2b_392",    0, 1, 10'd392, 0, 3'd1, 0, 0);
        add("s2b_530",    0, 1, 10'd530, 0, 3'd0, 0, 0);
        add("s2b_500",    0, 1, 10'd500, 0, 3'd0, 0, 0);
        // Scenario 3: restart on an extra G.
        add("s3_g1",      0, 1, G, 0, 3'd1, 0, 0);
        add("s3_g2",      0, 1, G, 0, 3'd2, 0, 0);
        add("s3_g_extra", 0, 1, G, 0, 3'd2, 0, 0);
        add("s3_a",       0, 1, A, 0, 3'd3, 0, 0);
        add("s3_g3",      0, 1, G, 0, 3'd4, 0, 0);
        add("s3_c",       0, 1, C, 0, 3'd5, 0, 0);
        add("s3_b_det",   0, 1, B, 0, 3'd0, 1, 0);
        add("s3b_g1",     0, 1, G, 0, 3'd1, 0, 0);
        add("s3b_g2",     0, 1, G, 0, 3'd2, 0, 0);
        add("s3b_a",      0, 1, A, 0, 3'd3, 0, 0);
        add("s3b_g3",     0, 1, G, 0, 3'd4, 0, 0);
        add("s3b_g_rest", 0, 1, G, 0, 3'd2, 0, 0);
        // Scenario 5: reset mid-phrase, including a note in the reset cycle.
        add("s5_reset",   1, 0, 10'd0, 0, 3'd0, 0, 0);
        add("s5_g1",      0, 1, G, 0, 3'd1, 0, 0);
        add("s5_g2",      0, 1, G, 0, 3'd2, 0, 0);
        add("s5_a",       0, 1, A, 0, 3'd3, 0, 0);
        add("s5_g3",      0, 1, G, 0, 3'd4, 0, 0);
        add("s5_rst",     1, 0, 10'd0, 0, 3'd0, 0, 0);
        add("s5_c",       0, 1, C, 0, 3'd0, 0, 0);
        add("s5_b",       0, 1, B, 0, 3'd0, 0, 0);
        add("s5_g",       0, 1, G, 0, 3'd1, 0, 0);
        add("s5_rst_vld", 1, 1, G, 0, 3'd0, 0, 0);
        // Scenario 6: back-to-back phrase, then ignored counts while valid is low.
        add("s6_g1",      0, 1, G, 0, 3'd1, 0, 0);
        add("s6_g2",      0, 1, G, 0, 3'd2, 0, 0);
        add("s6_a",       0, 1, A, 0, 3'd3, 0, 0);
        add("s6_g3",      0, 1, G, 0, 3'd4, 0, 0);
        add("s6_c",       0, 1, C, 0, 3'd5, 0, 0);
        add("s6_b_det",   0, 1, B, 0, 3'd0, 1, 0);
        add("s6_g",       0, 1, G, 0, 3'd1, 0, 0);
        add("s6_novld_g", 0, 0, G, 0, 3'd1, 0, 0);
        add("s6_novld_a", 0, 0, A, 0, 3'd1, 0, 0);
        add("s6_novld_x", 0, 0, 10'd1000, 0, 3'd1, 0, 0);

        repeat (2) @(posedge i_clk);
        foreach (vecs[i]) step(vecs[i]);

        // Scenario 4: timeout after G G A, and a note landing on the timeout cycle.
        run_timeout(1'b0);
        run_timeout(1'b1);

        if (sb.size() != 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/melody_detector.md
Name: melody_detector

Overview:
- Downstream consumer of the tone generator's note stream.
- Each o_count_valid/o_count pair from the generator is one note code, a tone frequency in Hz.
- Matches the incoming note stream against the opening phrase of "Happy Birthday": G G A G C B.
- Tolerance and inter-note timeout are applied; one pulse is raised per complete phrase.
- Output drives the top-level LED/indicator logic.

Parameters:
- NOTE_G, 392, note code for G4 (10-bit).
- NOTE_A, 440, note code for A4.
- NOTE_B, 494, note code for B4.
- NOTE_C, 523, note code for C5.
- TOL, 8, max absolute difference (inclusive) for a note to count as equal; range 0..63.
- TIMEOUT, 64, idle cycles after the last valid note before partial progress is discarded; range 2..65535.

Ports:
- i_clk, input, 1, single clock, rising edge.
- i_rst, input, 1, synchronous active-high reset.
- i_count_valid, input, 1, note strobe from the generator; one note per high cycle.
- i_count, input, 10, note code; sampled only when i_count_valid=1.
- o_progress, output, 3, number of phrase notes currently matched (0..5).
- o_detected, output, 1, one-cycle pulse when the 6th note completes the phrase.
- o_timeout, output, 1, one-cycle pulse when partial progress is abandoned by timeout.

Behaviour:
- Reset (i_rst=1 at a rising edge): o_progress=0, o_detected=0, o_timeout=0, idle counter=0. Reset overrides every other event, including a valid note in the same cycle.
- Phrase ROM, index 0..5: G, G, A, G, C, B. Fixed order; only the codes are parameterised.
- Match function:
  - match(x,N) = |x-N| <= TOL.
  - Computed on 11-bit zero-extended operands with unsigned absolute difference; no wrap.
  - Combinational, no pipeline.
- State is k = o_progress. All outputs are registered and update on the edge that samples the valid note (latency 1 cycle from the valid cycle).
- On a valid note x with current state k:
  - match(x,ROM[k]) and k<5: k<=k+1.
  - match(x,ROM[5]) and k=5: k<=0 and o_detected<=1 for one cycle. No overlapping detections.
  - Mismatch and match(x,NOTE_G):
    - k<=2 if k>=1 and ROM[k-1]=G (covers GG+G and GGAG+G).
    - Otherwise k<=1.
  - Mismatch and not G: k<=0.
- If TOL makes x match more than one code, ROM[k] is checked first; the mismatch/restart rules apply only when ROM[k] fails.
- Idle counter (16-bit):
  - Cleared on every valid note and whenever k=0.
  - Otherwise increments by 1 per cycle without valid, saturating.
  - When the counter reaches TIMEOUT-1 while k>0 and no valid note is present: next edge k<=0, o_timeout<=1 for one cycle, counter<=0.
- Simultaneous valid note and timeout cycle: the valid note wins, normal match rules apply, no o_timeout.
- o_detected and o_timeout are never high in the same cycle. Both are deasserted in every cycle without their triggering event.
- Consecutive valid cycles (back-to-back notes) are fully supported, one note per cycle.
- i_count is ignored when i_count_valid=0.

Test Plan:
1. Reset, then valid notes 392, 392, 440, 392, 523, 494, each 10 cycles apart.
   -> o_progress 1, 2, 3, 4, 5, 0; o_detected high for exactly one cycle, the cycle after the 494 strobe.
2. Notes 395, 388, 447, 392, 530, 500 with TOL=8.
   -> detection as in scenario 1.
   - Repeat with the 3rd note = 449 (diff 9) -> o_progress falls to 0 at that note; no detection.
3. Notes G, G, G, A, G, C, B.
   -> progress 1, 2, 2, 3, 4, 5, then o_detected pulse.
   - Also: G, G, A, G, G -> progress ends at 2.
4. Notes G, G, A, then no valid for TIMEOUT=64 cycles.
   -> o_timeout pulses once, 64 cycles after the A strobe; o_progress=0.
   - Same sequence with the 4th note arriving exactly on the timeout cycle -> progress 4, no o_timeout.
5. Notes G, G, A, G, then i_rst high for 1 cycle, then C, B.
   -> o_progress 0 after reset; C and B leave progress at 0; no o_detected.
6. Back-to-back valid on 6 consecutive cycles with the full phrase.
   -> progress 1..5, then o_detected on cycle 7.
   - Also: i_count toggling with i_count_valid=0 -> no state change.
